// File: rtl/max_finder.sv
// Searches a burst of N_INPUTS IEEE-754 single-precision values for the largest one
// and reports it with its 0-based arrival position.
module max_finder #(
    parameter int N_INPUTS = 10,
    parameter int IDX_W    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    output logic [31:0]      max_value,
    output logic [IDX_W-1:0] max_index,
    output logic             busy,
    output logic             done,
    output logic [1:0]       dbg_state_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } state_e;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_INPUTS - 1);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic [31:0]      cand_val_q, cand_val_d;
    logic [IDX_W-1:0] cand_idx_q, cand_idx_d;
    logic [31:0]      max_val_q, max_val_d;
    logic [IDX_W-1:0] max_idx_q, max_idx_d;

    logic             xfer;
    logic             replace;
    logic [31:0]      next_val;
    logic [IDX_W-1:0] next_idx;

    function automatic logic is_nan(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    endfunction

    // Strict sign-magnitude greater-than; +0 and -0 are equal.
    function automatic logic gt(input logic [31:0] a, input logic [31:0] b);
        logic res;
        if ((a[30:0] == 31'd0) && (b[30:0] == 31'd0))
            res = 1'b0;
        else if (a[31] != b[31])
            res = b[31];
        else if (!a[31])
            res = a[30:0] > b[30:0];
        else
            res = a[30:0] < b[30:0];
        return res;
    endfunction

    assign xfer     = (state_q == COLLECT) && in_valid;
    assign replace  = (cnt_q == '0) ||
                      (!is_nan(in_data) && (is_nan(cand_val_q) || gt(in_data, cand_val_q)));
    assign next_val = replace ? in_data : cand_val_q;
    assign next_idx = replace ? cnt_q : cand_idx_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cand_val_d = cand_val_q;
        cand_idx_d = cand_idx_q;
        max_val_d  = max_val_q;
        max_idx_d  = max_idx_q;
        in_ready   = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = COLLECT;
                    cnt_d   = '0;
                end
            end
            COLLECT: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (xfer) begin
                    cand_val_d = next_val;
                    cand_idx_d = next_idx;
                    // Final transfer publishes the result as DONE is entered.
                    if (cnt_q == LAST_IDX) begin
                        state_d   = DONE;
                        max_val_d = next_val;
                        max_idx_d = next_idx;
                    end else begin
                        cnt_d = cnt_q + IDX_W'(1);
                    end
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            cand_val_q <= 32'h0000_0000;
            cand_idx_q <= '0;
            max_val_q  <= 32'h0000_0000;
            max_idx_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cand_val_q <= cand_val_d;
            cand_idx_q <= cand_idx_d;
            max_val_q  <= max_val_d;
            max_idx_q  <= max_idx_d;
        end
    end

    assign max_value   = max_val_q;
    assign max_index   = max_idx_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_max_finder.sv
// Directed vector bench for max_finder: table of ten-value searches with
// hand-computed results, plus stall, mid-search start and reset-abort sequences.
module tb_max_finder;

    localparam int N  = 10;
    localparam int IW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [31:0]   in_data = 32'h0;
    logic [31:0]   max_value;
    logic [IW-1:0] max_index;
    logic          busy;
    logic          done;
    logic [1:0]    dbg_state;

    max_finder #(.N_INPUTS(N), .IDX_W(IW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .max_value  (max_value),
        .max_index  (max_index),
        .busy       (busy),
        .done       (done),
        .dbg_state_o(dbg_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0][31:0] vals;
        logic [31:0]        exp_val;
        logic [IW-1:0]      exp_idx;
    } vec_t;

    localparam int NV = 8;
    vec_t vec [NV];

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    logic [31:0]   hold_val = 32'h0;
    logic [IW-1:0] hold_idx = '0;

    always @(negedge clk) if (done) done_cnt++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_vec(input int k,
                           input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] a2,
                           input logic [31:0] a3, input logic [31:0] a4, input logic [31:0] a5,
                           input logic [31:0] a6, input logic [31:0] a7, input logic [31:0] a8,
                           input logic [31:0] a9, input logic [31:0] ev, input logic [IW-1:0] ei);
        vec[k].vals[0] = a0; vec[k].vals[1] = a1; vec[k].vals[2] = a2;
        vec[k].vals[3] = a3; vec[k].vals[4] = a4; vec[k].vals[5] = a5;
        vec[k].vals[6] = a6; vec[k].vals[7] = a7; vec[k].vals[8] = a8;
        vec[k].vals[9] = a9;
        vec[k].exp_val = ev;
        vec[k].exp_idx = ei;
    endtask

    task automatic run_search(input int k, input bit stall, input bit mid_start);
        int d0;
        d0 = done_cnt;
        // in_valid while idle must be ignored
        in_valid = 1'b1;
        in_data  = 32'h7F00_0000;
        @(posedge clk); #1;
        chk("idle_in_ready", 32'(in_ready), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        in_valid = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("collect_busy", 32'(busy), 32'd1);
        chk("collect_in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < N; i++) begin
            if (stall) begin
                in_valid = 1'b0;
                in_data  = $urandom;
                start    = mid_start;
                @(posedge clk); #1;
                start = 1'b0;
                chk("stall_busy", 32'(busy), 32'd1);
                chk("stall_hold_val", max_value, hold_val);
            end
            in_valid = 1'b1;
            in_data  = vec[k].vals[i];
            @(posedge clk); #1;
            if (i < N - 1) begin
                chk("collect_hold_val", max_value, hold_val);
                chk("collect_hold_idx", 32'(max_index), 32'(hold_idx));
                chk("collect_no_done", 32'(done), 32'd0);
            end
        end
        in_valid = 1'b0;
        chk("done_pulse", 32'(done), 32'd1);
        chk("done_busy", 32'(busy), 32'd0);
        chk("done_in_ready", 32'(in_ready), 32'd0);
        chk("max_value", max_value, vec[k].exp_val);
        chk("max_index", 32'(max_index), 32'(vec[k].exp_idx));
        hold_val = vec[k].exp_val;
        hold_idx = vec[k].exp_idx;
        @(posedge clk); #1;
        chk("after_done_low", 32'(done), 32'd0);
        chk("after_in_ready", 32'(in_ready), 32'd0);
        chk("after_hold_val", max_value, hold_val);
        chk("done_count", 32'(done_cnt - d0), 32'd1);
    endtask

    initial begin
        set_vec(0, 32'h3DCCCCCD, 32'h3E4CCCCD, 32'h3E99999A, 32'h3ECCCCCD, 32'h3F000000,
                   32'h3F19999A, 32'h3F333333, 32'h3F4CCCCD, 32'h3F666666, 32'h3F800000,
                   32'h3F800000, 4'd9);
        set_vec(1, 32'hBE4CCCCD, 32'h3E4CCCCD, 32'h40000000, 32'hBF800000, 32'h00000000,
                   32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000,
                   32'h40000000, 4'd2);
        set_vec(2, 32'h80000000, 32'h00000000, 32'h80000000, 32'h00000000, 32'h80000000,
                   32'h00000000, 32'h80000000, 32'h00000000, 32'h80000000, 32'h00000000,
                   32'h80000000, 4'd0);
        set_vec(3, 32'h3F000000, 32'h00000000, 32'h3F000000, 32'h3F800000, 32'h00000000,
                   32'h3F000000, 32'h00000000, 32'h3F800000, 32'h3F000000, 32'h00000000,
                   32'h3F800000, 4'd3);
        set_vec(4, 32'h7FC00000, 32'hBF800000, 32'hBF800000, 32'hBF800000, 32'hBF800000,
                   32'hBF800000, 32'hBF800000, 32'hBF800000, 32'hBF800000, 32'hBF800000,
                   32'hBF800000, 4'd1);
        set_vec(5, 32'h3F800000, 32'h3F000000, 32'h3F000000, 32'h3F000000, 32'h3F000000,
                   32'h7FC00000, 32'h3F000000, 32'h3F000000, 32'h3F000000, 32'h3F000000,
                   32'h3F800000, 4'd0);
        set_vec(6, 32'hBF800000, 32'hC0000000, 32'hBF000000, 32'hC0400000, 32'hBF800000,
                   32'hBF800000, 32'hBF800000, 32'hBF800000, 32'hBF800000, 32'hBF800000,
                   32'hBF000000, 4'd2);
        set_vec(7, 32'hFF800000, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h00000000, 32'h7F7FFFFF,
                   32'hBF800000, 32'h7F800000, 32'h7F7FFFFF, 32'h7FC00000, 32'h7F800000,
                   32'h7F800000, 4'd6);

        // Reset values while the clock has not yet ticked
        #1;
        chk("rst_max_value", max_value, 32'h0);
        chk("rst_max_index", 32'(max_index), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int k = 0; k < NV; k++) run_search(k, 1'b0, 1'b0);

        // Stalled input with start pulses during COLLECT: same results, one done
        run_search(0, 1'b1, 1'b1);
        run_search(1, 1'b1, 1'b0);
        run_search(3, 1'b1, 1'b1);

        // Reset abort after four transfers
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = 32'h7F7F_FFFF;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        begin
            int d0;
            d0 = done_cnt;
            #2 rst_n = 1'b0;
            #1;
            chk("abort_max_value", max_value, 32'h0);
            chk("abort_max_index", 32'(max_index), 32'd0);
            chk("abort_busy", 32'(busy), 32'd0);
            chk("abort_in_ready", 32'(in_ready), 32'd0);
            chk("abort_done", 32'(done), 32'd0);
            hold_val = 32'h0;
            hold_idx = '0;
            @(posedge clk); #1;
            rst_n    = 1'b1;
            in_valid = 1'b1;
            in_data  = 32'h7F7F_FFFF;
            for (int i = 0; i < 12; i++) begin
                @(posedge clk); #1;
                chk("abort_stays_idle", 32'(busy), 32'd0);
            end
            in_valid = 1'b0;
            chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
        end
        run_search(1, 1'b0, 1'b0);
        run_search(4, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
